// File: rtl/pe_fc_mac_seq.sv
// pe_fc_mac_seq: sequential fully-connected neuron.
// Accumulates NUM_INPUTS products of IEEE-754 single-precision activation and
// weight pairs onto a bias. The result passes through an optional ReLU and is
// then offered on a valid/ready handshake. One pair costs 1+MUL_LAT+ADD_LAT
// clocks (ACCEPT, MUL wait, ADD wait).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, bias, relu_en   begin a neuron (honoured in IDLE only), bias and ReLU sampled with start
//   in_valid/in_ready      operand pair handshake (input_fc, iweight_fc)
//   out_valid/out_ready    result handshake (output_fc)
//   busy                   high whenever not IDLE
//   elem_cnt               products accumulated so far (saturates at NUM_INPUTS)
//
// fpMul and fp_add are combinational single-precision units. They use
// round-to-nearest-even and flush subnormals to zero. Their latency is
// modelled by the FSM timer: operands sit in registers for the whole wait.

module fpMul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sy, hi, g, st;
  logic [47:0] prod;
  logic [23:0] m24;
  logic [24:0] mr;
  logic [10:0] e;

  always_comb begin
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    sy     = a[31] ^ b[31];
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    hi     = prod[47];
    m24    = hi ? prod[47:24] : prod[46:23];
    g      = hi ? prod[23] : prod[22];
    st     = hi ? |prod[22:0] : |prod[21:0];
    mr     = {1'b0, m24} + 25'(g & (st | m24[0]));
    // Exponent kept as 11-bit two's complement so underflow shows in e[10].
    e      = 11'(a[30:23]) + 11'(b[30:23]) + 11'(hi) + 11'(mr[24]) - 11'd127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      y = {sy, 8'hFF, 23'b0};
    end else if (a_zero || b_zero || e[10] || (e == '0)) begin
      y = {sy, 31'b0};
    end else if (e >= 11'd255) begin
      y = {sy, 8'hFF, 23'b0};
    end else begin
      y = {sy, e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
  end
endmodule

module fp_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        a_big, sub, carry, zero_res, g, st;
  logic [31:0] big, sml;
  logic [7:0]  d;
  logic [5:0]  dc;
  logic [49:0] tmp;
  logic [26:0] small27, big27, diff, r27;
  logic [27:0] sum28;
  logic [4:0]  lz;
  logic [23:0] m24;
  logic [24:0] mr;
  logic [10:0] e;

  always_comb begin
    a_zero   = (a[30:23] == 8'h00);
    b_zero   = (b[30:23] == 8'h00);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    sum28    = '0;
    diff     = '0;
    carry    = 1'b0;
    zero_res = 1'b0;
    lz       = '0;
    a_big    = (a[30:0] >= b[30:0]);
    big      = a_big ? a : b;
    sml      = a_big ? b : a;
    d        = big[30:23] - sml[30:23];
    // Beyond 49 places the smaller operand only contributes its sticky bit.
    dc       = (d > 8'd49) ? 6'd49 : d[5:0];
    tmp      = {1'b1, sml[22:0], 26'b0} >> dc;
    small27  = {tmp[49:24], |tmp[23:0]};
    big27    = {1'b1, big[22:0], 3'b000};
    sub      = big[31] ^ sml[31];
    if (!sub) begin
      sum28 = {1'b0, big27} + {1'b0, small27};
      carry = sum28[27];
      r27   = carry ? {sum28[27:2], |sum28[1:0]} : sum28[26:0];
    end else begin
      diff     = big27 - small27;
      zero_res = (diff == '0);
      for (int unsigned i = 0; i < 27; i++) begin
        if (diff[i]) lz = 5'(26 - i);
      end
      r27 = diff << lz;
    end
    m24 = r27[26:3];
    g   = r27[2];
    st  = |r27[1:0];
    mr  = {1'b0, m24} + 25'(g & (st | m24[0]));
    e   = 11'(big[30:23]) + 11'(carry) + 11'(mr[24]) - 11'(lz);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) begin
      y = 32'h7FC0_0000;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {a[31] & b[31], 31'b0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else if (zero_res) begin
      y = '0;
    end else if (e[10] || (e == '0)) begin
      y = {big[31], 31'b0};
    end else if (e >= 11'd255) begin
      y = {big[31], 8'hFF, 23'b0};
    end else begin
      y = {big[31], e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
  end
endmodule

module pe_fc_mac_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned MUL_LAT    = 1,
  parameter int unsigned ADD_LAT    = 1,
  parameter int unsigned CNT_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  relu_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] input_fc,
  input  logic [DATA_WIDTH-1:0] iweight_fc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] output_fc,
  output logic                  busy,
  output logic [CNT_W-1:0]      elem_cnt
);
  localparam int unsigned LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned TMR_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, ACCEPT, MUL, ADD, DONE} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] acc, a_q, w_q, p_q, product, sum;
  logic                  relu_q;
  logic [TMR_W-1:0]      timer;
  logic                  timer_zero, last_elem;

  assign timer_zero = (timer == '0);
  assign last_elem  = (elem_cnt == CNT_W'(NUM_INPUTS - 1));

  fpMul u_mul (.a(a_q), .b(w_q), .y(product));
  fp_add u_add (.a(acc), .b(p_q), .y(sum));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCEPT;
      ACCEPT:  if (in_valid) next_state = MUL;
      MUL:     if (timer_zero) next_state = ADD;
      ADD:     if (timer_zero) next_state = last_elem ? DONE : ACCEPT;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCEPT);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // The result register is loaded on the final ADD so that it is already
  // valid (and then held) for the whole of DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      a_q       <= '0;
      w_q       <= '0;
      p_q       <= '0;
      relu_q    <= 1'b0;
      timer     <= '0;
      elem_cnt  <= '0;
      output_fc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= bias;
            relu_q   <= relu_en;
            elem_cnt <= '0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            a_q   <= input_fc;
            w_q   <= iweight_fc;
            timer <= TMR_W'(MUL_LAT - 1);
          end
        end
        MUL: begin
          if (timer_zero) begin
            p_q   <= product;
            timer <= TMR_W'(ADD_LAT - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ADD: begin
          if (timer_zero) begin
            acc      <= sum;
            elem_cnt <= elem_cnt + CNT_W'(1);
            if (last_elem) begin
              output_fc <= (relu_q && sum[DATA_WIDTH-1]) ? '0 : sum;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_fc_mac_seq.sv
// Bench for pe_fc_mac_seq: four instances with different parameter sets,
// directed vector table, reset/stall/spurious-input sequences and random
// neurons checked against a real-arithmetic dot-product model.
module tb_pe_fc_mac_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s[4], relu_s[4], in_valid_s[4], out_ready_s[4];
  logic [31:0] bias_s[4], a_s[4], w_s[4];
  logic        in_ready_s[4], out_valid_s[4], busy_s[4];
  logic [31:0] out_s[4];
  logic [4:0]  ec0;
  logic [2:0]  ec1;
  logic [1:0]  ec2;
  logic [0:0]  ec3;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] av_g[16], wv_g[16];

  always #5 clk = ~clk;

  pe_fc_mac_seq #(.DATA_WIDTH(32), .NUM_INPUTS(16), .MUL_LAT(1), .ADD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .bias(bias_s[0]), .relu_en(relu_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .input_fc(a_s[0]), .iweight_fc(w_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .output_fc(out_s[0]), .busy(busy_s[0]),
    .elem_cnt(ec0));
  pe_fc_mac_seq #(.DATA_WIDTH(32), .NUM_INPUTS(4), .MUL_LAT(1), .ADD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .bias(bias_s[1]), .relu_en(relu_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .input_fc(a_s[1]), .iweight_fc(w_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .output_fc(out_s[1]), .busy(busy_s[1]),
    .elem_cnt(ec1));
  pe_fc_mac_seq #(.DATA_WIDTH(32), .NUM_INPUTS(2), .MUL_LAT(1), .ADD_LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .bias(bias_s[2]), .relu_en(relu_s[2]),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .input_fc(a_s[2]), .iweight_fc(w_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .output_fc(out_s[2]), .busy(busy_s[2]),
    .elem_cnt(ec2));
  pe_fc_mac_seq #(.DATA_WIDTH(32), .NUM_INPUTS(1), .MUL_LAT(3), .ADD_LAT(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .bias(bias_s[3]), .relu_en(relu_s[3]),
    .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]), .input_fc(a_s[3]), .iweight_fc(w_s[3]),
    .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]), .output_fc(out_s[3]), .busy(busy_s[3]),
    .elem_cnt(ec3));

  typedef struct {
    int unsigned      idx;
    logic [31:0]      bias;
    logic             relu;
    logic [3:0][31:0] a;
    logic [3:0][31:0] w;
    logic [31:0]      expv;
    int               lat;
    string            name;
  } vec_t;

  vec_t tbl[6];

  function automatic int unsigned n_of(input int unsigned idx);
    case (idx)
      0: return 16;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned step_of(input int unsigned idx);
    return (idx == 3) ? 6 : 3;
  endfunction

  function automatic int get_ec(input int unsigned idx);
    case (idx)
      0: return int'(ec0);
      1: return int'(ec1);
      2: return int'(ec2);
      default: return int'(ec3);
    endcase
  endfunction

  // Exact encoder for the dyadic values used here (no rounding needed).
  function automatic logic [31:0] f2b(input real r);
    real         m;
    int          e;
    logic        s;
    logic [22:0] fr;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    fr = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), fr};
  endfunction

  task automatic chk_hex(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Runs one neuron on instance idx. Entered and left at posedge+1.
  // vmode: 0 in_valid always, 1 pattern 1-0-0-1, 2 random.
  task automatic run_neuron(input int unsigned idx, input logic [31:0] bias, input logic relu,
                            input logic [31:0] av[16], input logic [31:0] wv[16],
                            input int unsigned vmode, input int unsigned stall, input bit spur,
                            input logic [31:0] expv, input int lat, input string name);
    int unsigned n = n_of(idx);
    int unsigned cyc = 0;
    int unsigned k = 0;
    bit          done = 1'b0;
    bit          v, hs;
    logic [31:0] held;
    bias_s[idx] = bias;
    relu_s[idx] = relu;
    start_s[idx] = 1'b1;
    out_ready_s[idx] = 1'b0;
    while (!done && cyc < 3000) begin
      if (cyc > 0) begin
        start_s[idx] = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        bias_s[idx]  = spur ? $urandom : bias;
        relu_s[idx]  = spur ? 1'($urandom_range(0, 1)) : relu;
      end
      case (vmode)
        0: v = 1'b1;
        1: v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: v = ($urandom_range(0, 9) < 6);
      endcase
      v = v && (k < n);
      if (in_ready_s[idx] || !spur) begin
        in_valid_s[idx] = v;
        a_s[idx] = (k < 16) ? av[k] : 32'h0;
        w_s[idx] = (k < 16) ? wv[k] : 32'h0;
      end else begin
        in_valid_s[idx] = 1'($urandom_range(0, 1));
        a_s[idx] = $urandom;
        w_s[idx] = $urandom;
      end
      hs = in_valid_s[idx] && in_ready_s[idx];
      @(posedge clk);
      #1;
      cyc++;
      if (hs) k++;
      if (out_valid_s[idx]) done = 1'b1;
    end
    in_valid_s[idx] = 1'b0;
    start_s[idx] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no out_valid within %0d cycles", name, cyc);
      return;
    end
    if (lat >= 0) chk_int({name, " latency"}, int'(cyc), lat);
    chk_hex({name, " result"}, out_s[idx], expv);
    chk_int({name, " elem_cnt"}, get_ec(idx), int'(n));
    chk_int({name, " pairs"}, int'(k), int'(n));
    held = out_s[idx];
    for (int unsigned s = 0; s < stall; s++) begin
      start_s[idx] = spur;
      @(posedge clk);
      #1;
      chk_int({name, " stall valid"}, int'(out_valid_s[idx]), 1);
      chk_hex({name, " stall hold"}, out_s[idx], held);
    end
    out_ready_s[idx] = 1'b1;
    start_s[idx] = spur;
    @(posedge clk);
    #1;
    out_ready_s[idx] = 1'b0;
    start_s[idx] = 1'b0;
    chk_int({name, " out_valid drop"}, int'(out_valid_s[idx]), 0);
    chk_int({name, " idle busy"}, int'(busy_s[idx]), 0);
    chk_hex({name, " idle hold"}, out_s[idx], held);
  endtask

  task automatic run_random(input int unsigned idx, input int unsigned vmode,
                            input int unsigned stall, input bit spur, input string name);
    int unsigned n = n_of(idx);
    real         acc, ra, rw;
    logic [31:0] b;
    logic        relu;
    logic [31:0] expv;
    acc  = real'(int'($urandom_range(0, 30)) - 15) / 4.0;
    b    = f2b(acc);
    relu = 1'($urandom_range(0, 1));
    for (int unsigned i = 0; i < 16; i++) begin
      ra = real'(int'($urandom_range(0, 30)) - 15) / 4.0;
      rw = real'(int'($urandom_range(0, 30)) - 15) / 4.0;
      av_g[i] = f2b(ra);
      wv_g[i] = f2b(rw);
      if (i < n) acc = acc + ra * rw;
    end
    expv = (relu && acc < 0.0) ? 32'h0 : f2b(acc);
    run_neuron(idx, b, relu, av_g, wv_g, vmode, stall, spur, expv,
               (vmode == 0) ? int'(1 + step_of(idx) * n) : -1, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned guard;
    bit          hs;

    tbl[0] = '{1, 32'h0, 1'b0, {4{32'h3F800000}}, {4{32'h40000000}}, 32'h41000000, 13, "n4_sum8"};
    tbl[1] = '{2, 32'h3F800000, 1'b1, {32'h0, 32'h0, 32'h3F000000, 32'hBF800000},
               {32'h0, 32'h0, 32'h3F800000, 32'h40400000}, 32'h00000000, 7, "n2_relu_on"};
    tbl[2] = '{2, 32'h3F800000, 1'b0, {32'h0, 32'h0, 32'h3F000000, 32'hBF800000},
               {32'h0, 32'h0, 32'h3F800000, 32'h40400000}, 32'hBFC00000, 7, "n2_relu_off"};
    tbl[3] = '{3, 32'h40000000, 1'b0, {4{32'h40000000}}, {4{32'h40000000}}, 32'h40C00000, 7, "n1_lat32"};
    tbl[4] = '{1, 32'hBF800000, 1'b1, {32'h0, 32'h3F800000, 32'hC0800000, 32'h40000000},
               {32'h0, 32'h3F800000, 32'h3F000000, 32'h40400000}, 32'h40800000, 13, "n4_mixed"};
    tbl[5] = '{3, 32'h0, 1'b1, {4{32'hC0000000}}, {4{32'h40000000}}, 32'h00000000, 7, "n1_relu_neg"};

    rst_n = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      start_s[i] = 1'b1; relu_s[i] = 1'b0; in_valid_s[i] = 1'b1; out_ready_s[i] = 1'b0;
      bias_s[i] = 32'h3F800000; a_s[i] = 32'h0; w_s[i] = 32'h0;
    end
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk_hex("reset output_fc", out_s[i], 32'h0);
      chk_int("reset out_valid", int'(out_valid_s[i]), 0);
      chk_int("reset busy", int'(busy_s[i]), 0);
      chk_int("reset in_ready", int'(in_ready_s[i]), 0);
      chk_int("reset elem_cnt", get_ec(i), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; in_valid_s[i] = 1'b0;
    end
    rst_n = 1'b1;

    // Directed table; the first start lands on the first edge after reset release.
    for (int unsigned t = 0; t < 6; t++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        av_g[i] = (i < 4) ? tbl[t].a[i] : 32'h0;
        wv_g[i] = (i < 4) ? tbl[t].w[i] : 32'h0;
      end
      run_neuron(tbl[t].idx, tbl[t].bias, tbl[t].relu, av_g, wv_g, 0, t % 3, 1'b0,
                 tbl[t].expv, tbl[t].lat, tbl[t].name);
    end

    // Asynchronous reset in the middle of a neuron.
    start_s[0] = 1'b1; bias_s[0] = 32'h3F800000; relu_s[0] = 1'b0;
    in_valid_s[0] = 1'b1; a_s[0] = 32'h3F800000; w_s[0] = 32'h3F800000;
    k = 0;
    guard = 0;
    while (k < 2 && guard < 100) begin
      hs = in_valid_s[0] && in_ready_s[0];
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      guard++;
      if (hs) k++;
    end
    chk_int("midreset pairs taken", int'(k), 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_int("midreset out_valid", int'(out_valid_s[0]), 0);
    chk_int("midreset busy", int'(busy_s[0]), 0);
    chk_int("midreset in_ready", int'(in_ready_s[0]), 0);
    chk_int("midreset elem_cnt", get_ec(0), 0);
    chk_hex("midreset output_fc", out_s[0], 32'h0);
    in_valid_s[0] = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_random(0, 0, 1, 1'b0, "after_reset");

    // Handshake stalls: in_valid 1-0-0-1, out_ready held low 5 cycles.
    run_random(0, 1, 5, 1'b0, "stall_pattern");
    // Spurious start / in_valid outside their states.
    run_random(0, 2, 2, 1'b1, "spurious");
    run_random(3, 1, 3, 1'b1, "spurious_lat32");

    for (int unsigned r = 0; r < 10; r++) begin
      run_random(r % 4, r % 3, $urandom_range(0, 4), r[0], "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
